// File: rtl/chunked_copy_pkg.sv
// Shared types for the chunked bus copier:
// FSM state encoding and per-word transform modes.
package chunked_copy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] MODE_COPY = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_BREV = 2'b10;
  localparam logic [1:0] MODE_CREV = 2'b11;

endpackage

// File: rtl/chunked_bus_copier_xform.sv
// Per-chunk transform: copy, invert or bit-reverse.
// Chunk-order reverse is chosen by the parent's mux.
module chunk_xform
  import chunked_copy_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] data_i,
  input  logic [1:0]       mode_i,
  output logic [CHUNK-1:0] data_o
);

  // Select the transform; CREV chunks pass through.
  always_comb begin
    data_o = data_i;
    case (mode_i)
      MODE_INV: data_o = ~data_i;
      MODE_BREV: begin
        for (int j = 0; j < CHUNK; j++) begin
          data_o[j] = data_i[CHUNK-1-j];
        end
      end
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/chunked_bus_copier.sv
// Time-multiplexed bus copier: one W-bit word in,
// CHUNK bits transformed per clock, one word out.
module chunked_bus_copier
  import chunked_copy_pkg::*;
#(
  parameter int W     = 256,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int N     = W / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [W-1:0]     src_q, src_d;
  logic [W-1:0]     out_q, out_d;
  logic [1:0]       mode_q, mode_d;

  logic [CNT_W-1:0] sel;
  logic [CHUNK-1:0] chunk_raw;
  logic [CHUNK-1:0] chunk_new;

  // Pick the source chunk; CREV reads from the far end.
  always_comb begin
    sel = k_q;
    if (mode_q == MODE_CREV) sel = K_LAST - k_q;
    chunk_raw = src_q[int'(sel)*CHUNK +: CHUNK];
  end

  chunk_xform #(
    .CHUNK(CHUNK)
  ) u_xform (
    .data_i(chunk_raw),
    .mode_i(mode_q),
    .data_o(chunk_new)
  );

  // Next-state, counter and datapath updates.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    src_d   = src_q;
    mode_d  = mode_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d   = in_data;
          mode_d  = in_mode;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        out_d[int'(k_q)*CHUNK +: CHUNK] = chunk_new;
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      src_q   <= '0;
      mode_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      src_q   <= src_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;

endmodule

// File: tb/tb_chunked_bus_copier.sv
// Directed and swept checks for chunked_bus_copier:
// vector table, backpressure, mid-word reset, width sweep.
module tb_chunked_bus_copier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  logic         s_in_valid;
  logic [255:0] s_in_data;
  logic [1:0]   s_in_mode;
  logic         s_out_ready;
  logic         s_in_ready  [3];
  logic         s_out_valid [3];
  logic [255:0] s_out_data  [3];
  logic         s_busy      [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  chunked_bus_copier #(.W(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  chunked_bus_copier #(.W(256), .CHUNK(8)) dut_c8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready[0]),
    .in_data(s_in_data), .in_mode(s_in_mode),
    .out_valid(s_out_valid[0]), .out_ready(s_out_ready),
    .out_data(s_out_data[0]), .busy(s_busy[0])
  );

  chunked_bus_copier #(.W(256), .CHUNK(32)) dut_c32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready[1]),
    .in_data(s_in_data), .in_mode(s_in_mode),
    .out_valid(s_out_valid[1]), .out_ready(s_out_ready),
    .out_data(s_out_data[1]), .busy(s_busy[1])
  );

  chunked_bus_copier #(.W(256), .CHUNK(256)) dut_c256 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready[2]),
    .in_data(s_in_data), .in_mode(s_in_mode),
    .out_valid(s_out_valid[2]), .out_ready(s_out_ready),
    .out_data(s_out_data[2]), .busy(s_busy[2])
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  m;
    logic [31:0] e;
    string       name;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] ref_model(
    input logic [255:0] d, input logic [1:0] m,
    input int w, input int c);
    logic [255:0] r;
    int n;
    r = '0;
    n = w / c;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < c; j++) begin
        case (m)
          2'b00: r[k*c+j] = d[k*c+j];
          2'b01: r[k*c+j] = ~d[k*c+j];
          2'b10: r[k*c+j] = d[k*c+c-1-j];
          default: r[k*c+j] = d[(n-1-k)*c+j];
        endcase
      end
    end
    return r;
  endfunction

  // One word through the W=32 instance with out_ready=1,
  // scrambling inputs while busy to show they are ignored.
  task automatic run_word(input logic [31:0] d,
                          input logic [1:0] m,
                          input logic [31:0] e,
                          input string name);
    int  lat;
    bit  ir_low;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    chk({name, " in_ready@accept"}, 256'(in_ready), 256'(1));
    @(negedge clk);
    in_data = ~d;
    in_mode = ~m;
    lat     = 1;
    ir_low  = 1'b1;
    while (!out_valid && lat < 20) begin
      if (in_ready || !busy) ir_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (in_ready || !busy) ir_low = 1'b0;
    chk({name, " latency"}, 256'(lat), 256'(5));
    chk({name, " data"}, 256'(out_data), 256'(e));
    chk({name, " in_ready low"}, 256'(ir_low), 256'(1));
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, " in_ready after"}, 256'(in_ready), 256'(1));
    chk({name, " out_valid after"}, 256'(out_valid), 256'(0));
  endtask

  initial begin
    logic [31:0] held;
    int lat;
    int lat_rec [3];
    bit done [3];
    logic [255:0] got [3];
    logic [255:0] exp256;
    int cw [3];

    tbl[0] = '{32'h1234_5678, 2'b00, 32'h1234_5678, "copy"};
    tbl[1] = '{32'h0F0F_00FF, 2'b01, 32'hF0F0_FF00, "inv"};
    tbl[2] = '{32'h0102_0380, 2'b10, 32'h8040_C001, "brev"};
    tbl[3] = '{32'hAABB_CCDD, 2'b11, 32'hDDCC_BBAA, "crev"};
    tbl[4] = '{32'hFFFF_FFFF, 2'b01, 32'h0000_0000, "inv_ones"};
    tbl[5] = '{32'h0000_0001, 2'b11, 32'h0100_0000, "crev_one"};
    tbl[6] = '{32'h8000_0001, 2'b10, 32'h0100_0080, "brev_edge"};
    cw[0] = 8;
    cw[1] = 32;
    cw[2] = 256;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_mode     = '0;
    out_ready   = 1'b1;
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_in_mode   = '0;
    s_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst out_data", 256'(out_data), 256'(0));
    chk("rst out_valid", 256'(out_valid), 256'(0));
    chk("rst in_ready", 256'(in_ready), 256'(1));
    chk("rst busy", 256'(busy), 256'(0));

    for (int i = 0; i < 7; i++) begin
      run_word(tbl[i].d, tbl[i].m, tbl[i].e, tbl[i].name);
    end

    // Backpressure: hold DONE for 10 cycles.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAABB_CCDD;
    in_mode   = 2'b00;
    @(negedge clk);
    in_data = 32'h5555_5555;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency", 256'(lat), 256'(5));
    held = out_data;
    chk("bp data", 256'(held), 256'(32'hAABB_CCDD));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp out_valid", 256'(out_valid), 256'(1));
      chk("bp stable", 256'(out_data), 256'(held));
      chk("bp in_ready", 256'(in_ready), 256'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", 256'(out_valid), 256'(0));
    chk("bp release in_ready", 256'(in_ready), 256'(1));
    chk("bp no 2nd word", 256'(out_data), 256'(32'hAABB_CCDD));
    chk("bp busy", 256'(busy), 256'(0));

    // Reset after two chunks of a word.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    in_mode  = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst out_data", 256'(out_data), 256'(0));
    chk("midrst out_valid", 256'(out_valid), 256'(0));
    chk("midrst in_ready", 256'(in_ready), 256'(1));
    chk("midrst busy", 256'(busy), 256'(0));
    run_word(32'h0000_0001, 2'b00, 32'h0000_0001, "post_rst");

    // Width sweep across CHUNK = 8, 32, 256.
    for (int m = 0; m < 4; m++) begin
      for (int r = 0; r < 2; r++) begin
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_mode  = 2'(m);
        for (int b = 0; b < 8; b++) begin
          s_in_data[b*32 +: 32] = $urandom;
        end
        for (int i = 0; i < 3; i++) begin
          chk("sweep in_ready", 256'(s_in_ready[i]), 256'(1));
          done[i] = 1'b0;
          lat_rec[i] = 0;
          got[i] = '0;
        end
        @(negedge clk);
        s_in_valid = 1'b0;
        lat = 1;
        while (lat < 60 && !(done[0] && done[1] && done[2])) begin
          for (int i = 0; i < 3; i++) begin
            if (!done[i] && s_out_valid[i]) begin
              done[i]    = 1'b1;
              lat_rec[i] = lat;
              got[i]     = s_out_data[i];
            end
          end
          if (!(done[0] && done[1] && done[2])) begin
            @(negedge clk);
            lat++;
          end
        end
        for (int i = 0; i < 3; i++) begin
          exp256 = ref_model(s_in_data, 2'(m), 256, cw[i]);
          chk($sformatf("sweep c%0d m%0d done", cw[i], m),
              256'(done[i]), 256'(1));
          chk($sformatf("sweep c%0d m%0d latency", cw[i], m),
              256'(lat_rec[i]), 256'(256 / cw[i] + 1));
          chk($sformatf("sweep c%0d m%0d data", cw[i], m),
              got[i], exp256);
        end
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
